// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Round-robin arbiter that shares one 32-bit SDRAM bus-core client
//   interface among N requesters. Each requester holds a level request
//   until it sees a one-cycle p_done (completed) or p_err (watchdog abort).
//   Every access is followed by a RELEASE cycle with read/write low so the
//   bus core always drops back to its idle state before the next grant.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   p_read/p_write      per-port level requests (write wins if both high)
//   p_addr/p_writedata  per-port packed fields, port k at [W*k +: W]
//   p_done/p_err        per-port one-cycle completion / timeout pulses
//   p_readdata          read data captured on sdram_finished
//   sdram_*             bus-core client interface
//   grant_id            current / last granted port
//   busy                high in GRANT and RELEASE
module sdram_arbiter #(
    parameter int N       = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N-1:0]      p_read,
    input  logic [N-1:0]      p_write,
    input  logic [N*23-1:0]   p_addr,
    input  logic [N*32-1:0]   p_writedata,
    output logic [N-1:0]      p_done,
    output logic [N-1:0]      p_err,
    output logic [31:0]       p_readdata,
    output logic [22:0]       sdram_addr,
    output logic              sdram_read,
    output logic              sdram_write,
    output logic [31:0]       sdram_writedata,
    input  logic [31:0]       sdram_readdata,
    input  logic              sdram_finished,
    output logic [1:0]        grant_id,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    // Reset value of 'last' makes port 0 the first winner.
    localparam logic [1:0]  LAST0  = 2'(N - 1);
    localparam logic [15:0] TO_MAX = 16'(TIMEOUT - 1);

    state_t               state;
    logic [1:0]           last;
    logic [15:0]          cnt;
    logic [N-1:0]         req;
    logic [1:0]           pick;
    logic [N-1:0]         gnt_oh;
    logic [N-1:0][22:0]   addr_a;
    logic [N-1:0][31:0]   wdata_a;
    logic                 rd_g;
    logic                 wr_g;

    assign req     = p_read | p_write;
    assign addr_a  = p_addr;
    assign wdata_a = p_writedata;
    assign gnt_oh  = N'(1) << grant_id;
    assign rd_g    = p_read[grant_id];
    assign wr_g    = p_write[grant_id];

    // Round-robin: lowest requesting port above 'last' if there is one,
    // otherwise wrap to the lowest requesting port overall.
    always_comb begin
        pick = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[k]) pick = 2'(k);
        for (int k = N - 1; k >= 0; k--)
            if (req[k] && (2'(k) > last)) pick = 2'(k);
    end

    // Address/data are steered from grant_id in every state; only GRANT
    // makes them meaningful because read/write are low elsewhere.
    assign sdram_addr      = addr_a[grant_id];
    assign sdram_writedata = wdata_a[grant_id];
    assign sdram_write     = (state == GRANT) && wr_g;
    assign sdram_read      = (state == GRANT) && rd_g && !wr_g;
    assign busy            = (state != IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            last       <= LAST0;
            grant_id   <= '0;
            cnt        <= '0;
            p_readdata <= '0;
            p_done     <= '0;
            p_err      <= '0;
        end else begin
            p_done <= '0;
            p_err  <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_id <= pick;
                        last     <= pick;
                        cnt      <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // finished beats abort beats timeout
                    if (sdram_finished) begin
                        p_readdata <= sdram_readdata;
                        p_done     <= gnt_oh;
                        state      <= RELEASE;
                    end else if (!(rd_g || wr_g)) begin
                        state <= RELEASE;
                    end else if (cnt == TO_MAX) begin
                        p_err <= gnt_oh;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    localparam int N    = 3;
    localparam int TO_A = 8;
    localparam int TO_B = 4;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [N-1:0]      p_read = '0;
    logic [N-1:0]      p_write = '0;
    logic [N*23-1:0]   p_addr = '0;
    logic [N*32-1:0]   p_writedata = '0;
    logic [N-1:0]      p_done, p_err, b_done, b_err;
    logic [31:0]       p_readdata, b_readdata;
    logic [22:0]       sdram_addr, b_addr;
    logic              sdram_read, sdram_write, b_read, b_write;
    logic [31:0]       sdram_writedata, b_writedata;
    logic [31:0]       sdram_readdata = 32'hBAD0_0BAD;
    logic              sdram_finished = 1'b0;
    logic [1:0]        grant_id, b_grant_id;
    logic              busy, b_busy;

    sdram_arbiter #(.N(N), .TIMEOUT(TO_A)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .p_read(p_read), .p_write(p_write),
        .p_addr(p_addr), .p_writedata(p_writedata), .p_done(p_done), .p_err(p_err),
        .p_readdata(p_readdata), .sdram_addr(sdram_addr), .sdram_read(sdram_read),
        .sdram_write(sdram_write), .sdram_writedata(sdram_writedata),
        .sdram_readdata(sdram_readdata), .sdram_finished(sdram_finished),
        .grant_id(grant_id), .busy(busy));

    // Short-watchdog copy sharing all inputs, used for the finished/timeout tie.
    sdram_arbiter #(.N(N), .TIMEOUT(TO_B)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .p_read(p_read), .p_write(p_write),
        .p_addr(p_addr), .p_writedata(p_writedata), .p_done(b_done), .p_err(b_err),
        .p_readdata(b_readdata), .sdram_addr(b_addr), .sdram_read(b_read),
        .sdram_write(b_write), .sdram_writedata(b_writedata),
        .sdram_readdata(sdram_readdata), .sdram_finished(sdram_finished),
        .grant_id(b_grant_id), .busy(b_busy));

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          port;
        bit          err;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int grant_cyc = 0;
    int fin_cyc = 0;
    int pulse_cnt = 0;
    logic busy_q = 1'b0;

    bit cfg_rd[N];
    bit cfg_wr[N];
    int rem[N];

    int bus_lat = 1000;
    int bus_cnt = 0;
    bit bus_fixed_en = 0;
    logic [31:0] bus_fixed = '0;
    logic [31:0] model_rdata = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Requesters: hold request while accesses remain, drop on done/err,
    // reissue in the following cycle.
    always @(posedge i_clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (p_done[k] || p_err[k]) begin
                p_read[k] = 1'b0; p_write[k] = 1'b0;
                if (rem[k] > 0) rem[k]--;
            end else if (rem[k] == 0) begin
                p_read[k] = 1'b0; p_write[k] = 1'b0;
            end else if (!p_read[k] && !p_write[k]) begin
                p_read[k] = cfg_rd[k]; p_write[k] = cfg_wr[k];
            end
        end
    end

    // Bus core model: finished strobe bus_lat cycles after read/write rises.
    always @(posedge i_clk) begin
        #2;
        sdram_finished = 1'b0;
        sdram_readdata = 32'hBAD0_0BAD;
        if (sdram_read || sdram_write) begin
            if (bus_cnt == bus_lat) begin
                sdram_finished = 1'b1;
                sdram_readdata = bus_fixed_en ? bus_fixed : {9'h155, sdram_addr};
                model_rdata    = sdram_readdata;
                bus_cnt = 0;
            end else begin
                bus_cnt++;
            end
        end else begin
            bus_cnt = 0;
        end
    end

    // Scoreboard monitor for the main instance.
    always @(negedge i_clk) begin
        if (i_rst) begin
            busy_q = 1'b0;
        end else begin
            if (busy && !busy_q) grant_cyc = cyc;
            if (sdram_finished) fin_cyc = cyc;
            if (|p_done || |p_err) begin
                pulse_cnt++;
                total++;
                if (sdram_read || sdram_write) begin
                    bad++;
                    $display("FAIL release_rw: rd=%0b wr=%0b required 0 0", sdram_read, sdram_write);
                end
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: done=%b err=%b required none", p_done, p_err);
                end else begin
                    logic [N-1:0] xd, xe;
                    e  = exp_q.pop_front();
                    xd = e.err ? '0 : N'(1) << e.port;
                    xe = e.err ? N'(1) << e.port : '0;
                    if ({p_done, p_err} !== {xd, xe}) begin
                        bad++;
                        $display("FAIL pulse: done=%b err=%b required done=%b err=%b", p_done, p_err, xd, xe);
                    end
                    if (grant_id !== 2'(e.port)) begin
                        bad++;
                        $display("FAIL grant_order: grant_id=%0d required %0d", grant_id, e.port);
                    end
                    if (!e.err && cyc !== fin_cyc + 1) begin
                        bad++;
                        $display("FAIL done_latency: cycle=%0d required %0d", cyc, fin_cyc + 1);
                    end
                    if (e.err && cyc - grant_cyc !== TO_A) begin
                        bad++;
                        $display("FAIL err_latency: %0d cycles after first GRANT cycle, required %0d", cyc - grant_cyc, TO_A);
                    end
                    if (e.chk && p_readdata !== e.data) begin
                        bad++;
                        $display("FAIL readdata: got %h required %h", p_readdata, e.data);
                    end
                end
            end
            busy_q = busy;
        end
    end

    task automatic set_port(input int k, input bit rd, input bit wr,
                            input logic [22:0] a, input logic [31:0] d);
        cfg_rd[k] = rd;
        cfg_wr[k] = wr;
        p_addr[k*23 +: 23]      = a;
        p_writedata[k*32 +: 32] = d;
    endtask

    task automatic push(input int k, input bit err, input bit chk, input logic [31:0] d);
        exp_t x;
        x.port = k; x.err = err; x.chk = chk; x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 20) begin @(negedge i_clk); n++; end
        total++;
        if (!busy) begin bad++; $display("FAIL %s_wait_busy: busy=0 required 1", name); end
    endtask

    task automatic drain(input string name, input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin @(negedge i_clk); n++; end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_reset();
        for (int k = 0; k < N; k++) rem[k] = 0;
        @(negedge i_clk); i_rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({p_done, p_err, busy, sdram_read, sdram_write, grant_id} !== '0 || p_readdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_values: done=%b err=%b busy=%b rd=%b wr=%b gid=%0d rdata=%h required all 0",
                     p_done, p_err, busy, sdram_read, sdram_write, grant_id, p_readdata);
        end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_req: busy=%b required 0", busy); end
    endtask

    task automatic test_fairness();
        bus_fixed_en = 0; bus_lat = 1;
        for (int k = 0; k < N; k++) set_port(k, 1, 0, 23'(16'h100 + k), 0);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push(k, 0, 1, {9'h155, 23'(16'h100 + k)});
        for (int k = 0; k < N; k++) rem[k] = 2;
        drain("fairness", 100);
    endtask

    task automatic test_single_read();
        bus_fixed_en = 1; bus_fixed = 32'hDEADBEEF; bus_lat = 4;
        set_port(1, 1, 0, 23'h000010, 0);
        push(1, 0, 1, 32'hDEADBEEF);
        rem[1] = 1;
        @(negedge i_clk);
        wait_busy("single");
        total++;
        if (grant_id !== 2'd1 || sdram_read !== 1'b1 || sdram_addr !== 23'h000010) begin
            bad++;
            $display("FAIL single_grant: gid=%0d rd=%b addr=%h required 1 1 000010", grant_id, sdram_read, sdram_addr);
        end
        drain("single", 30);
        bus_fixed_en = 0;
    endtask

    task automatic test_write_precedence();
        bus_lat = 2;
        set_port(0, 1, 1, 23'h7FFFFF, 32'h12345678);
        push(0, 0, 0, 0);
        rem[0] = 1;
        @(negedge i_clk);
        wait_busy("wprec");
        total++;
        if (sdram_write !== 1'b1 || sdram_read !== 1'b0 || sdram_addr !== 23'h7FFFFF ||
            sdram_writedata !== 32'h12345678) begin
            bad++;
            $display("FAIL write_precedence: wr=%b rd=%b addr=%h wdata=%h required 1 0 7fffff 12345678",
                     sdram_write, sdram_read, sdram_addr, sdram_writedata);
        end
        drain("wprec", 30);
    endtask

    task automatic test_timeout();
        bus_lat = 1000;
        set_port(2, 1, 0, 23'h000002, 0);
        push(2, 1, 0, 0);
        rem[2] = 1;
        drain("timeout", 40);
        repeat (2) @(negedge i_clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_abort_reset();
        int p0;
        bus_lat = 1000;
        p0 = pulse_cnt;
        set_port(0, 1, 0, 23'h000005, 0);
        rem[0] = 1;
        @(negedge i_clk);
        wait_busy("abort");
        repeat (2) @(negedge i_clk);
        rem[0] = 0;
        repeat (4) @(negedge i_clk);
        total++;
        if (busy !== 1'b0 || pulse_cnt !== p0 || p_readdata !== model_rdata) begin
            bad++;
            $display("FAIL abort: busy=%b pulses=%0d rdata=%h required 0 0 %h",
                     busy, pulse_cnt - p0, p_readdata, model_rdata);
        end
        // reset in the middle of a grant
        set_port(1, 1, 0, 23'h000007, 0);
        rem[1] = 1;
        @(negedge i_clk);
        wait_busy("rst");
        @(negedge i_clk);
        i_rst = 1'b1;
        for (int k = 0; k < N; k++) rem[k] = 0;
        exp_q.delete();
        #1;
        total++;
        if ({p_done, p_err, busy, sdram_read, sdram_write, grant_id} !== '0 || p_readdata !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset: done=%b err=%b busy=%b rd=%b wr=%b gid=%0d rdata=%h required all 0",
                     p_done, p_err, busy, sdram_read, sdram_write, grant_id, p_readdata);
        end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        bus_lat = 2;
        set_port(0, 1, 0, 23'h000020, 0);
        set_port(1, 1, 0, 23'h000021, 0);
        push(0, 0, 1, {9'h155, 23'h000020});
        push(1, 0, 1, {9'h155, 23'h000021});
        rem[0] = 1; rem[1] = 1;
        drain("after_reset", 40);
    endtask

    task automatic test_finish_vs_timeout();
        int nd = 0, ne = 0;
        pulse_reset();
        bus_lat = 3;
        set_port(0, 1, 0, 23'h000030, 0);
        push(0, 0, 1, {9'h155, 23'h000030});
        rem[0] = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (b_done[0]) nd++;
            if (|b_err) ne++;
        end
        total++;
        if (nd !== 1 || ne !== 0) begin
            bad++;
            $display("FAIL finish_vs_timeout: done pulses=%0d err pulses=%0d required 1 0", nd, ne);
        end
        drain("tie", 5);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin rem[k] = 0; cfg_rd[k] = 0; cfg_wr[k] = 0; end
        test_reset();
        test_fairness();
        test_single_read();
        test_write_precedence();
        test_timeout();
        test_abort_reset();
        test_finish_vs_timeout();
        repeat (3) @(negedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
